// File: rtl/rr_mux_reg.sv
// rr_mux_reg: registered N:1 word multiplexer with valid/ready handshaking.
// Selects one of CHANNELS producers by fixed priority (mode=0) or
// round-robin (mode=1) and holds the chosen word in an output register
// until the consumer takes it.
module rr_mux_reg #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int SELW     = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      mode,
  input  logic [CHANNELS-1:0]       in_valid,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  output logic [CHANNELS-1:0]       in_ready,
  output logic                      out_valid,
  output logic [WIDTH-1:0]          out_data,
  output logic [SELW-1:0]           out_sel,
  input  logic                      out_ready
);

  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  logic [SELW-1:0]  out_sel_q;
  logic [SELW-1:0]  last_q;

  logic             load;
  logic [SELW-1:0]  grant_idx;
  logic             hi_found;
  logic [SELW-1:0]  hi_idx;
  logic             lo_found;
  logic [SELW-1:0]  lo_idx;

  // Register accepts a new word when empty or being drained this cycle.
  always_comb begin
    load = (!out_valid_q || out_ready) && (|in_valid) && !reset;
  end

  // Grant search. The round-robin wrap search (last+1 .. last) is split
  // into two ascending scans: channels above last win first, otherwise the
  // lowest requester at or below last. With mode=0 only the second scan is
  // used, which reduces to plain lowest-index priority.
  always_comb begin
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_found = 1'b0;
    lo_idx   = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (in_valid[i]) begin
        if (mode && (SELW'(i) > last_q)) begin
          if (!hi_found) begin
            hi_found = 1'b1;
            hi_idx   = SELW'(i);
          end
        end else if (!lo_found) begin
          lo_found = 1'b1;
          lo_idx   = SELW'(i);
        end
      end
    end
    grant_idx = hi_found ? hi_idx : lo_idx;
  end

  // One-hot accept strobe to the granted channel, only when loading.
  always_comb begin
    in_ready = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      in_ready[i] = load && (grant_idx == SELW'(i));
    end
  end

  // Output register and round-robin pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      last_q      <= SELW'(CHANNELS - 1);
    end else if (load) begin
      out_valid_q <= 1'b1;
      out_data_q  <= in_data[grant_idx*WIDTH +: WIDTH];
      out_sel_q   <= grant_idx;
      last_q      <= grant_idx;
    end else if (out_valid_q && out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_rr_mux_reg.sv
// Directed bench for rr_mux_reg (CHANNELS=4, WIDTH=8). Expected output
// words go into a scoreboard queue; a monitor pops one per output transfer.
module tb_rr_mux_reg;

  localparam int WIDTH    = 8;
  localparam int CHANNELS = 4;
  localparam int SELW     = 2;

  logic                      clk;
  logic                      reset;
  logic                      mode;
  logic [CHANNELS-1:0]       in_valid;
  logic [CHANNELS*WIDTH-1:0] in_data;
  logic [CHANNELS-1:0]       in_ready;
  logic                      out_valid;
  logic [WIDTH-1:0]          out_data;
  logic [SELW-1:0]           out_sel;
  logic                      out_ready;

  int checks = 0;
  int errors = 0;

  logic [SELW+WIDTH-1:0] exp_q[$];

  rr_mux_reg #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) dut (
    .clk      (clk),
    .reset    (reset),
    .mode     (mode),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_sel  (out_sel),
    .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int ch, input logic [WIDTH-1:0] v);
    in_data[ch*WIDTH +: WIDTH] = v;
  endtask

  task automatic push(input logic [SELW-1:0] s, input logic [WIDTH-1:0] d);
    exp_q.push_back({s, d});
  endtask

  // Monitor: inputs change just after posedge, so the negedge view is what
  // the next posedge will see; a transfer there consumes one expected word.
  initial begin
    logic [SELW+WIDTH-1:0] e;
    forever begin
      @(negedge clk);
      if (reset === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got sel=%0d data=%0h expected none at %0t",
                   out_sel, out_data, $time);
        end else begin
          e = exp_q.pop_front();
          check("sb_sel", 32'(out_sel), 32'(e[SELW+WIDTH-1:WIDTH]));
          check("sb_data", 32'(out_data), 32'(e[WIDTH-1:0]));
        end
      end
    end
  end

  initial begin
    reset     = 1'b1;
    mode      = 1'b0;
    in_valid  = 4'b1111;
    in_data   = '0;
    out_ready = 1'b1;

    // Reset with all channels requesting.
    for (int c = 0; c < 2; c++) begin
      step();
      check("rst_valid", 32'(out_valid), 0);
      check("rst_data", 32'(out_data), 0);
      check("rst_sel", 32'(out_sel), 0);
      check("rst_in_ready", 32'(in_ready), 0);
    end

    // Fixed priority: ch1 beats ch3.
    reset    = 1'b0;
    mode     = 1'b0;
    in_valid = 4'b1010;
    set_ch(1, 8'hAA);
    set_ch(3, 8'h55);
    for (int c = 0; c < 4; c++) begin
      push(2'd1, 8'hAA);
      #1;
      check("fp_in_ready", 32'(in_ready), 32'b0010);
      step();
      check("fp_sel", 32'(out_sel), 1);
      check("fp_data", 32'(out_data), 32'hAA);
    end
    in_valid = '0;
    step();
    check("fp_drained", 32'(out_valid), 0);

    // Round-robin from a fresh pointer.
    reset = 1'b1;
    step();
    reset = 1'b0;
    mode  = 1'b1;
    in_valid = 4'b1111;
    for (int i = 0; i < CHANNELS; i++) set_ch(i, 8'(8'h10 + i));
    for (int c = 0; c < 8; c++) begin
      push(2'(c % 4), 8'(8'h10 + (c % 4)));
      #1;
      check("rr_in_ready", 32'(in_ready), 32'(1 << (c % 4)));
      step();
      check("rr_sel", 32'(out_sel), 32'(c % 4));
    end
    in_valid = '0;
    step();

    // Back-pressure then resume without a bubble.
    mode     = 1'b0;
    in_valid = 4'b0010;
    set_ch(1, 8'h11);
    push(2'd1, 8'h11);
    step();
    out_ready = 1'b0;
    set_ch(1, 8'h22);
    for (int c = 0; c < 3; c++) begin
      #1;
      check("bp_valid", 32'(out_valid), 1);
      check("bp_data", 32'(out_data), 32'h11);
      check("bp_in_ready", 32'(in_ready), 0);
      step();
    end
    check("bp_hold_data", 32'(out_data), 32'h11);
    out_ready = 1'b1;
    push(2'd1, 8'h22);
    #1;
    check("bp_resume_ready", 32'(in_ready), 32'b0010);
    step();
    check("bp_resume_data", 32'(out_data), 32'h22);
    check("bp_resume_valid", 32'(out_valid), 1);
    in_valid = '0;
    step();

    // Drain of a single word.
    in_valid = 4'b0100;
    set_ch(2, 8'h3C);
    push(2'd2, 8'h3C);
    step();
    in_valid = '0;
    check("dr_valid1", 32'(out_valid), 1);
    check("dr_data1", 32'(out_data), 32'h3C);
    step();
    check("dr_valid0", 32'(out_valid), 0);
    check("dr_data_hold", 32'(out_data), 32'h3C);
    check("dr_sel_hold", 32'(out_sel), 2);
    step();
    check("dr_valid_stay0", 32'(out_valid), 0);

    // Round-robin resumes after last=2 (ch3, ch0), then reset mid-stream.
    mode     = 1'b1;
    in_valid = 4'b1111;
    for (int i = 0; i < CHANNELS; i++) set_ch(i, 8'(8'h10 + i));
    push(2'd3, 8'h13);
    step();
    check("ms_sel_a", 32'(out_sel), 3);
    step();
    check("ms_sel_b", 32'(out_sel), 0);
    check("ms_valid_b", 32'(out_valid), 1);
    reset = 1'b1;
    #1;
    check("ms_rst_in_ready", 32'(in_ready), 0);
    step();
    check("ms_rst_valid", 32'(out_valid), 0);
    reset = 1'b0;
    push(2'd0, 8'h10);
    push(2'd1, 8'h11);
    #1;
    check("ms_first_grant", 32'(in_ready), 32'b0001);
    step();
    check("ms_post_sel", 32'(out_sel), 0);
    check("ms_post_data", 32'(out_data), 32'h10);
    step();
    in_valid = '0;
    step();
    step();

    check("sb_empty", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
